// File: rtl/motor_ramp_pkg.sv
// Shared types and constants for the four-channel motor ramp scheduler.
package motor_ramp_pkg;

    localparam int NUM_CHAN = 4;
    localparam int DUTY_W   = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DEAD = 2'd2
    } chan_state_t;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

    // Bridge pins {dir1, dir2}; only a running channel drives the bridge.
    function automatic logic [1:0] dir_pins(chan_state_t st, logic dir);
        if (st != RUN) begin
            return 2'b00;
        end
        return (dir == DIR_FWD) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/motor_ramp_step.sv
// Next-state computation for one serviced channel: ramp toward target,
// coast through a dead period before any direction reversal.
module motor_ramp_step
    import motor_ramp_pkg::*;
#(
    parameter int STEP       = 4,
    parameter int DEAD_TICKS = 8,
    parameter int CNT_W      = 4
) (
    input  chan_state_t       state,
    input  logic [DUTY_W-1:0] duty,
    input  logic              cur_dir,
    input  logic [CNT_W-1:0]  dead_cnt,
    input  logic [DUTY_W-1:0] tgt_duty,
    input  logic              tgt_dir,
    output chan_state_t       state_next,
    output logic [DUTY_W-1:0] duty_next,
    output logic              dir_next,
    output logic [CNT_W-1:0]  cnt_next
);

    localparam logic [DUTY_W-1:0] STEP_D    = DUTY_W'(STEP);
    localparam logic [CNT_W-1:0]  DEAD_LOAD = CNT_W'(DEAD_TICKS);

    logic [DUTY_W:0]   up_sum;
    logic [DUTY_W-1:0] down_diff;
    logic [DUTY_W-1:0] toward;
    logic [DUTY_W-1:0] ramp_down;
    logic              down_ok;

    // Ramp arithmetic: one extra bit on the way up, a guard on the way down.
    always_comb begin
        up_sum    = {1'b0, duty} + {1'b0, STEP_D};
        down_ok   = duty > STEP_D;
        down_diff = duty - STEP_D;
        ramp_down = down_ok ? down_diff : '0;
        toward    = duty;
        if (duty < tgt_duty) begin
            toward = (up_sum >= {1'b0, tgt_duty}) ? tgt_duty : up_sum[DUTY_W-1:0];
        end else if (duty > tgt_duty) begin
            toward = (!down_ok || down_diff <= tgt_duty) ? tgt_duty : down_diff;
        end
    end

    always_comb begin
        state_next = state;
        duty_next  = duty;
        dir_next   = cur_dir;
        cnt_next   = dead_cnt;
        case (state)
            IDLE: begin
                if (tgt_duty != '0) begin
                    state_next = RUN;
                    dir_next   = tgt_dir;
                    duty_next  = '0;
                end
            end
            RUN: begin
                if (duty == '0 && tgt_duty == '0) begin
                    state_next = IDLE;
                end else if (tgt_dir == cur_dir) begin
                    duty_next = toward;
                end else begin
                    duty_next = ramp_down;
                    if (ramp_down == '0) begin
                        state_next = DEAD;
                        cnt_next   = DEAD_LOAD;
                    end
                end
            end
            DEAD: begin
                duty_next = '0;
                cnt_next  = (dead_cnt == '0) ? '0 : dead_cnt - 1'b1;
                // A count of one (or zero) finishes on this service.
                if (dead_cnt <= CNT_W'(1)) begin
                    cnt_next = '0;
                    if (tgt_duty == '0) begin
                        state_next = IDLE;
                    end else begin
                        state_next = RUN;
                        dir_next   = tgt_dir;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                duty_next  = '0;
                cnt_next   = '0;
            end
        endcase
    end

endmodule

// File: rtl/motor_ramp_scheduler.sv
// Four-channel H-bridge ramp scheduler: tick-driven round-robin sweep with obstacle stop.
// Optional MOTOR_RAMP_MISS_CNT_EN adds tick_miss_cnt (ticks dropped during a sweep).
module motor_ramp_scheduler
    import motor_ramp_pkg::*;
#(
    parameter int STEP       = 4,
    parameter int DEAD_TICKS = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [1:0]                   cmd_chan,
    input  logic [DUTY_W-1:0]            cmd_duty,
    input  logic                         cmd_dir,
    input  logic                         tick,
    input  logic                         obstacle,
    output logic [NUM_CHAN*DUTY_W-1:0]   duty_out,
    output logic [NUM_CHAN-1:0]          dir1,
    output logic [NUM_CHAN-1:0]          dir2,
    output logic [NUM_CHAN-1:0]          busy
`ifdef MOTOR_RAMP_MISS_CNT_EN
    ,
    output logic [7:0]                   tick_miss_cnt
`endif
);

    localparam int CNT_W = (DEAD_TICKS < 2) ? 1 : $clog2(DEAD_TICKS + 1);
    localparam int IDX_W = $clog2(NUM_CHAN);

    chan_state_t       state_reg    [NUM_CHAN];
    chan_state_t       state_next   [NUM_CHAN];
    logic [DUTY_W-1:0] duty_reg     [NUM_CHAN];
    logic [DUTY_W-1:0] duty_next    [NUM_CHAN];
    logic              dir_reg      [NUM_CHAN];
    logic              dir_next     [NUM_CHAN];
    logic [CNT_W-1:0]  cnt_reg      [NUM_CHAN];
    logic [CNT_W-1:0]  cnt_next     [NUM_CHAN];
    logic [DUTY_W-1:0] tgt_duty_reg [NUM_CHAN];
    logic              tgt_dir_reg  [NUM_CHAN];

    logic              sweep_active_reg;
    logic              sweep_active_next;
    logic [IDX_W-1:0]  svc_idx_reg;
    logic [IDX_W-1:0]  svc_idx_next;

    chan_state_t       step_state;
    logic [DUTY_W-1:0] step_duty;
    logic              step_dir;
    logic [CNT_W-1:0]  step_cnt;
    logic              cmd_accept;

    assign cmd_ready  = ~reset;
    assign cmd_accept = cmd_valid & cmd_ready;

    // Sweep sequencer: a tick while idle services channels 0..3 on the next four edges.
    always_comb begin
        sweep_active_next = sweep_active_reg;
        svc_idx_next      = svc_idx_reg;
        if (sweep_active_reg) begin
            svc_idx_next = svc_idx_reg + 1'b1;
            if (svc_idx_reg == IDX_W'(NUM_CHAN - 1)) begin
                sweep_active_next = 1'b0;
            end
        end else if (tick) begin
            sweep_active_next = 1'b1;
            svc_idx_next      = '0;
        end
    end

    motor_ramp_step #(
        .STEP       (STEP),
        .DEAD_TICKS (DEAD_TICKS),
        .CNT_W      (CNT_W)
    ) u_step (
        .state      (state_reg[svc_idx_reg]),
        .duty       (duty_reg[svc_idx_reg]),
        .cur_dir    (dir_reg[svc_idx_reg]),
        .dead_cnt   (cnt_reg[svc_idx_reg]),
        .tgt_duty   (tgt_duty_reg[svc_idx_reg]),
        .tgt_dir    (tgt_dir_reg[svc_idx_reg]),
        .state_next (step_state),
        .duty_next  (step_duty),
        .dir_next   (step_dir),
        .cnt_next   (step_cnt)
    );

    // The obstacle override acts on every forward runner, serviced or not, and wins.
    always_comb begin
        for (int i = 0; i < NUM_CHAN; i++) begin
            state_next[i] = state_reg[i];
            duty_next[i]  = duty_reg[i];
            dir_next[i]   = dir_reg[i];
            cnt_next[i]   = cnt_reg[i];
            if (sweep_active_reg && svc_idx_reg == IDX_W'(i)) begin
                state_next[i] = step_state;
                duty_next[i]  = step_duty;
                dir_next[i]   = step_dir;
                cnt_next[i]   = step_cnt;
            end
            if (obstacle && state_reg[i] == RUN && dir_reg[i] == DIR_FWD) begin
                duty_next[i] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sweep_active_reg <= 1'b0;
            svc_idx_reg      <= '0;
            for (int i = 0; i < NUM_CHAN; i++) begin
                state_reg[i]    <= IDLE;
                duty_reg[i]     <= '0;
                dir_reg[i]      <= DIR_FWD;
                cnt_reg[i]      <= '0;
                tgt_duty_reg[i] <= '0;
                tgt_dir_reg[i]  <= DIR_FWD;
            end
        end else begin
            sweep_active_reg <= sweep_active_next;
            svc_idx_reg      <= svc_idx_next;
            for (int i = 0; i < NUM_CHAN; i++) begin
                state_reg[i] <= state_next[i];
                duty_reg[i]  <= duty_next[i];
                dir_reg[i]   <= dir_next[i];
                cnt_reg[i]   <= cnt_next[i];
                if (cmd_accept && cmd_chan == 2'(i)) begin
                    tgt_duty_reg[i] <= cmd_duty;
                    tgt_dir_reg[i]  <= cmd_dir;
                end
            end
        end
    end

`ifdef MOTOR_RAMP_MISS_CNT_EN
    logic [7:0] miss_cnt_reg;
    logic       tick_ignored;

    assign tick_ignored  = tick & sweep_active_reg;
    assign tick_miss_cnt = miss_cnt_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            miss_cnt_reg <= '0;
        end else if (tick_ignored && miss_cnt_reg != 8'hFF) begin
            miss_cnt_reg <= miss_cnt_reg + 8'd1;
        end
    end
`endif

    for (genvar gi = 0; gi < NUM_CHAN; gi++) begin : g_out
        assign duty_out[gi*DUTY_W +: DUTY_W] = duty_reg[gi];
        assign {dir1[gi], dir2[gi]}          = dir_pins(state_reg[gi], dir_reg[gi]);
        assign busy[gi]                      = (state_reg[gi] != IDLE);
    end

endmodule
